// File: rtl/wimax_pkg.sv
// Shared types, modulation constants and interleaver permutation helpers
// for the WiMAX receive-side block deinterleaver.
package wimax_pkg;

  typedef enum logic {
    bank_empty = 1'b0,
    bank_full  = 1'b1
  } bank_state_t;

  // Coded bits per carrier for each modulation
  localparam int unsigned NCPC_QPSK  = 2;
  localparam int unsigned NCPC_QAM16 = 4;
  localparam int unsigned NCPC_QAM64 = 6;

  // Rotation group size: max(ncpc/2, 1)
  function automatic int unsigned s_of(input int unsigned ncpc);
    return (ncpc / 2 > 1) ? ncpc / 2 : 32'd1;
  endfunction

  // First interleaver step: row/column block transpose
  function automatic logic [31:0] perm_first(input logic [31:0] k,
                                             input logic [31:0] ncbps,
                                             input logic [31:0] d);
    return (ncbps / d) * (k % d) + (k / d);
  endfunction

  // Second interleaver step: rotation inside groups of s bits
  function automatic logic [31:0] perm_second(input logic [31:0] m,
                                              input logic [31:0] ncbps,
                                              input logic [31:0] d,
                                              input logic [31:0] s);
    return s * (m / s) + ((m + ncbps - ((d * m) / ncbps)) % s);
  endfunction

  // Channel position of original bit k; the deinterleaver reads from here
  function automatic logic [31:0] perm(input logic [31:0] k,
                                       input logic [31:0] ncbps,
                                       input logic [31:0] d,
                                       input logic [31:0] s);
    return perm_second(perm_first(k, ncbps, d), ncbps, d, s);
  endfunction

endpackage

// File: rtl/deint_bank_ram.sv
// Two-bank 1-bit simple dual-port memory with synchronous, enabled read.
// Ports:
//   clk, rst_n   clock and async active-low reset (read register only)
//   i_wr_en      write strobe, i_wr_addr / i_wr_data write port
//   i_rd_en      read enable, i_rd_addr read address
//   o_rd_data    registered read data; holds when i_rd_en is low
module deint_bank_ram #(
  parameter int unsigned DEPTH  = 384,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic              i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_data
);

  logic r_mem [DEPTH];
  logic r_rd_data;

  // Storage array: no reset, contents are only read after being written
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read register doubles as the block's output data register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= 1'b0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/wimax_deinterleaver.sv
// WiMAX receive block deinterleaver: accepts coded bits in channel order and
// emits them in encoder order through a ping-pong pair of Ncbps-bit banks.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   valid_in, data_in   upstream bit (interleaved order)
//   ready_out           current write bank is empty
//   valid_out, data_out deinterleaved bit (original order)
//   ready_in            downstream accepts data_out
module wimax_deinterleaver
  import wimax_pkg::*;
#(
  parameter int unsigned NCBPS = 192,
  parameter int unsigned NCPC  = 2,
  parameter int unsigned D     = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid_in,
  input  logic data_in,
  output logic ready_out,
  output logic valid_out,
  output logic data_out,
  input  logic ready_in
);

  localparam int unsigned S      = s_of(NCPC);
  localparam int unsigned CNT_W  = $clog2(NCBPS);
  localparam int unsigned ADDR_W = $clog2(2 * NCBPS);
  localparam int unsigned DEPTH  = 2 * NCBPS;

  bank_state_t       r_bank_state [2];
  bank_state_t       w_bank_state_nxt [2];
  logic              r_wr_bank;
  logic              r_rd_bank;
  logic [CNT_W-1:0]  r_wr_cnt;
  logic [CNT_W-1:0]  r_rd_cnt;
  logic              r_valid_out;
  logic              r_ready_out;

  logic              w_wr_en;
  logic              w_wr_last;
  logic              w_rd_en;
  logic              w_rd_last;
  logic              w_wr_bank_nxt;
  logic              w_ready_nxt;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_ram_q;

  // Handshake qualifiers; r_ready_out always mirrors the write bank's state
  assign w_wr_en   = valid_in && r_ready_out;
  assign w_wr_last = w_wr_en && (r_wr_cnt == CNT_W'(NCBPS - 1));
  assign w_rd_en   = (r_bank_state[r_rd_bank] == bank_full) && (!r_valid_out || ready_in);
  assign w_rd_last = w_rd_en && (r_rd_cnt == CNT_W'(NCBPS - 1));

  // Writes are sequential; reads gather through the interleaver permutation
  assign w_wr_addr = ADDR_W'(32'(r_wr_bank) * NCBPS + 32'(r_wr_cnt));
  assign w_rd_addr = ADDR_W'(32'(r_rd_bank) * NCBPS + perm(32'(r_rd_cnt), NCBPS, D, S));

  // Per-bank next state; last write and last read always hit different banks
  always_comb begin
    w_bank_state_nxt = r_bank_state;
    w_wr_bank_nxt    = r_wr_bank;
    if (w_wr_last) begin
      w_bank_state_nxt[r_wr_bank] = bank_full;
      w_wr_bank_nxt               = ~r_wr_bank;
    end
    if (w_rd_last) begin
      w_bank_state_nxt[r_rd_bank] = bank_empty;
    end
    w_ready_nxt = (w_bank_state_nxt[w_wr_bank_nxt] == bank_empty);
  end

  // Bank state registers and write-side bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank_state[0] <= bank_empty;
      r_bank_state[1] <= bank_empty;
      r_wr_bank       <= 1'b0;
      r_ready_out     <= 1'b1;
    end else begin
      r_bank_state <= w_bank_state_nxt;
      r_wr_bank    <= w_wr_bank_nxt;
      r_ready_out  <= w_ready_nxt;
    end
  end

  // Write counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt <= '0;
    end else if (w_wr_en) begin
      r_wr_cnt <= w_wr_last ? '0 : r_wr_cnt + CNT_W'(1);
    end
  end

  // Read counter and read bank pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_cnt  <= '0;
      r_rd_bank <= 1'b0;
    end else if (w_rd_en) begin
      r_rd_cnt <= w_rd_last ? '0 : r_rd_cnt + CNT_W'(1);
      if (w_rd_last) begin
        r_rd_bank <= ~r_rd_bank;
      end
    end
  end

  // Output valid: set by a read issue, cleared only once consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_out <= 1'b0;
    end else if (w_rd_en) begin
      r_valid_out <= 1'b1;
    end else if (ready_in) begin
      r_valid_out <= 1'b0;
    end
  end

  deint_bank_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (data_in),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_ram_q)
  );

  assign ready_out = r_ready_out;
  assign valid_out = r_valid_out;
  assign data_out  = w_ram_q;

endmodule

// File: tb/tb_wimax_deinterleaver.sv
// Scoreboard bench for wimax_deinterleaver: QPSK/192 and 16-QAM/384 instances.
module tb_wimax_deinterleaver;

  localparam int NA = 192;
  localparam int CA = 2;
  localparam int NB = 384;
  localparam int CB = 4;
  localparam int DD = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic a_vi = 1'b0, a_di = 1'b0, a_ri = 1'b1;
  logic a_ro, a_vo, a_do;
  logic b_vi = 1'b0, b_di = 1'b0, b_ri = 1'b1;
  logic b_ro, b_vo, b_do;

  int passed = 0;
  int total  = 0;
  bit exp_a[$];
  bit exp_b[$];
  int a_acc = 0;
  int b_ro_low = 0;
  int b_rmode = 0;
  bit a_hold = 0, a_hold_d = 0;
  bit b_hold = 0, b_hold_d = 0;

  wimax_deinterleaver #(.NCBPS(NA), .NCPC(CA), .D(DD)) dut_a (
    .clk(clk), .rst_n(rst_n), .valid_in(a_vi), .data_in(a_di),
    .ready_out(a_ro), .valid_out(a_vo), .data_out(a_do), .ready_in(a_ri)
  );

  wimax_deinterleaver #(.NCBPS(NB), .NCPC(CB), .D(DD)) dut_b (
    .clk(clk), .rst_n(rst_n), .valid_in(b_vi), .data_in(b_di),
    .ready_out(b_ro), .valid_out(b_vo), .data_out(b_do), .ready_in(b_ri)
  );

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  // Transmit interleaver: channel position of encoder bit k
  function automatic int tx_pos(input int k, input int n, input int ncpc);
    int s, m;
    s = (ncpc / 2 > 1) ? ncpc / 2 : 1;
    m = (n / DD) * (k % DD) + k / DD;
    return s * (m / s) + (m + n - (DD * m) / n) % s;
  endfunction

  // Monitors: pop expected bit on every output transfer, check holds under backpressure
  always @(negedge clk) begin
    if (!rst_n) begin
      a_hold = 0;
    end else begin
      if (a_hold) check("a_hold_stable", int'({a_vo, a_do}), int'({1'b1, a_hold_d}));
      a_hold   = a_vo && !a_ri;
      a_hold_d = a_do;
      if (a_vo && a_ri) begin
        if (exp_a.size() == 0) check("a_unexpected_out", 0, 1);
        else check("a_data", int'(a_do), int'(exp_a.pop_front()));
      end
      if (a_vi && a_ro) a_acc++;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      b_hold = 0;
    end else begin
      if (b_hold) check("b_hold_stable", int'({b_vo, b_do}), int'({1'b1, b_hold_d}));
      b_hold   = b_vo && !b_ri;
      b_hold_d = b_do;
      if (b_vo && b_ri) begin
        if (exp_b.size() == 0) check("b_unexpected_out", 0, 1);
        else check("b_data", int'(b_do), int'(exp_b.pop_front()));
      end
    end
  end

  // Downstream ready for instance B: always high or randomly gapped
  always @(posedge clk) begin
    #1;
    b_ri = (b_rmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
  end

  task automatic a_send_bit(input bit v);
    int t = 0;
    bit done = 0;
    a_vi = 1'b1;
    a_di = v;
    while (!done) begin
      @(negedge clk);
      if (a_ro) done = 1;
      @(posedge clk); #1;
      t++;
      if (!done && t > 4000) begin
        check("a_accept_timeout", 0, 1);
        done = 1;
      end
    end
    a_vi = 1'b0;
  endtask

  task automatic b_send_bit(input bit v, input bit gaps);
    int t = 0;
    bit done = 0;
    if (gaps && $urandom_range(0, 2) == 0) begin
      b_vi = 1'b0;
      b_di = 1'($urandom);
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    b_vi = 1'b1;
    b_di = v;
    while (!done) begin
      @(negedge clk);
      if (b_ro) done = 1;
      else b_ro_low++;
      @(posedge clk); #1;
      t++;
      if (!done && t > 4000) begin
        check("b_accept_timeout", 0, 1);
        done = 1;
      end
    end
    b_vi = 1'b0;
  endtask

  // One-hot block: channel bit hot_in set, encoder bit hot_out expected
  task automatic a_send_onehot(input int hot_in, input int hot_out);
    for (int k = 0; k < NA; k++) exp_a.push_back(k == hot_out);
    for (int j = 0; j < NA; j++) a_send_bit(j == hot_in);
  endtask

  task automatic a_send_rand_block();
    bit src[NA];
    bit tx[NA];
    for (int k = 0; k < NA; k++) begin
      src[k] = 1'($urandom);
      exp_a.push_back(src[k]);
      tx[tx_pos(k, NA, CA)] = src[k];
    end
    for (int j = 0; j < NA; j++) a_send_bit(tx[j]);
  endtask

  task automatic b_send_block(input bit gaps, input int nbits);
    bit src[NB];
    bit tx[NB];
    for (int k = 0; k < NB; k++) begin
      src[k] = 1'($urandom);
      exp_b.push_back(src[k]);
      tx[tx_pos(k, NB, CB)] = src[k];
    end
    for (int j = 0; j < nbits; j++) b_send_bit(tx[j], gaps);
  endtask

  task automatic a_drain();
    int t = 0;
    while (exp_a.size() > 0 && t < 20000) begin @(posedge clk); t++; end
    check("a_drain_left", exp_a.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic b_drain();
    int t = 0;
    while (exp_b.size() > 0 && t < 40000) begin @(posedge clk); t++; end
    check("b_drain_left", exp_b.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #20000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int acc0, gaps;
    bit seen;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("a_reset_ready", int'(a_ro), 1);
    check("a_reset_valid", int'(a_vo), 0);
    check("a_reset_data", int'(a_do), 0);
    check("b_reset_ready", int'(b_ro), 1);
    check("b_reset_valid", int'(b_vo), 0);
    check("b_reset_data", int'(b_do), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-bit mapping on the QPSK/192 instance
    a_send_onehot(12, 1);
    a_send_onehot(1, 16);
    a_drain();

    // Backpressure: ready_in low for 400 cycles while upstream streams
    a_ri = 1'b0;
    acc0 = a_acc;
    fork
      begin
        repeat (3) a_send_rand_block();
      end
      begin
        repeat (400) @(posedge clk);
        #1;
        check("a_bp_accepts", a_acc - acc0, 2 * NA);
        check("a_bp_ready_low", int'(a_ro), 0);
        a_ri = 1'b1;
      end
    join
    a_drain();

    // Latency on the 16-QAM/384 instance from an empty pipeline
    b_send_block(0, NB);
    check("b_latency_edge1", int'(b_vo), 0);
    @(posedge clk); #1;
    check("b_latency_edge2", int'(b_vo), 1);
    b_drain();

    // Three back-to-back blocks: no output gaps, ready_out never drops
    b_ro_low = 0;
    gaps = 0;
    fork
      begin
        repeat (3) b_send_block(0, NB);
      end
      begin
        seen = 0;
        for (int i = 0; i < 4 * NB && !seen; i++) begin
          @(negedge clk);
          if (b_vo) seen = 1;
        end
        check("b_stream_started", int'(seen), 1);
        for (int i = 0; i < 3 * NB - 1; i++) begin
          @(negedge clk);
          if (!b_vo) gaps++;
        end
      end
    join
    check("b_stream_gaps", gaps, 0);
    check("b_stream_ready_low", b_ro_low, 0);
    b_drain();

    // Reset 100 bits into the second block
    b_send_block(0, NB);
    b_send_block(0, 100);
    rst_n = 1'b0;
    #1;
    check("b_midrst_ready", int'(b_ro), 1);
    check("b_midrst_valid", int'(b_vo), 0);
    check("b_midrst_data", int'(b_do), 0);
    exp_b.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    b_send_block(0, NB);
    b_drain();

    // Random valid/ready gaps, about 10k bits
    b_rmode = 1;
    for (int blk = 0; blk < 27; blk++) b_send_block(1, NB);
    b_drain();
    b_rmode = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
